// File: rtl/fp_sqrt_issue_pkg.sv
// Shared FP constants for the fixed-latency FP unit wrappers.
//   FP32_W         - single-precision word width
//   FP32_QNAN      - canonical quiet NaN
//   FPSQRT_LATENCY - pipeline depth of the FPSqrt unit
//   fifo_ptr_w()   - pointer width of a power-of-two FIFO (one wrap bit)
package fp_sqrt_issue_pkg;

    localparam int              FP32_W         = 32;
    localparam logic [31:0]     FP32_QNAN      = 32'h7FC0_0000;
    localparam int              FPSQRT_LATENCY = 16;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fp_sqrt_issue_if.sv
// Request/response bundle of the FP square-root issue wrapper.
//   in_*    - tagged request from FP dispatch (valid/ready)
//   sqrt_a  - operand to the sqrt unit, sqrt_q - its result
//   out_*   - tagged response to the consumer (valid/ready)
//   busy    - any request in flight or buffered
// master = dispatch/consumer/unit side, slave = the wrapper.
interface fp_sqrt_issue_if #(
    parameter int TAG_W = 8
);
    import fp_sqrt_issue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP32_W-1:0] in_a;
    logic [TAG_W-1:0]  in_tag;
    logic [FP32_W-1:0] sqrt_a;
    logic [FP32_W-1:0] sqrt_q;
    logic              out_valid;
    logic              out_ready;
    logic [FP32_W-1:0] out_q;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output in_valid, in_a, in_tag, out_ready, sqrt_q,
        input  in_ready, sqrt_a, out_valid, out_q, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_tag, out_ready, sqrt_q,
        output in_ready, sqrt_a, out_valid, out_q, out_tag, busy
    );

endinterface

// File: rtl/fp_resp_fifo.sv
// Show-ahead response FIFO shared by the fixed-latency FP unit wrappers.
//   clk, areset - clock, asynchronous active-low reset
//   wr_i/wdata_i - push (caller guarantees space)
//   rd_i         - pop of the head entry (ignored when empty)
//   rdata_o      - head entry, forced to zero when empty
//   empty_o      - no entry available
module fp_resp_fifo
    import fp_sqrt_issue_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    logic [PW-1:0]    wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty_o = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_i)
                wptr_q <= wptr_q + PW'(1);
            if (rd_i && !empty_o)
                rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_i)
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    // Upstream credit accounting must make this impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!areset) !(wr_i && full))
        else $error("fp_resp_fifo: write while full");

endmodule

// File: rtl/fp_sqrt_issue.sv
// Valid/ready issue wrapper around the non-stallable FPSqrt unit.
//   clk, areset - clock, asynchronous active-low reset
//   io (slave)  - request in, operand/result to the unit, response out, busy
// A request is issued only while a FIFO slot is reserved for its result
// (credit counter); a valid/tag shift register realigns the unit's output.
module fp_sqrt_issue
    import fp_sqrt_issue_pkg::*;
#(
    parameter int LATENCY    = FPSQRT_LATENCY,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic          clk,
    input  logic          areset,
    fp_sqrt_issue_if.slave io
);

    localparam int             CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  CREDITS = CW'(FIFO_DEPTH);

    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          in_ready_q;
    logic [LATENCY-1:0]            vld_sr_q;
    logic [LATENCY-1:0][TAG_W-1:0] tag_sr_q;
    logic                          issue, pop;
    logic                          fifo_empty;
    logic [FP32_W+TAG_W-1:0]       fifo_rdata;

    assign issue        = io.in_valid && in_ready_q;
    assign pop          = !fifo_empty && io.out_ready;
    assign io.in_ready  = in_ready_q;
    assign io.sqrt_a    = issue ? io.in_a : '0;
    assign io.out_valid = !fifo_empty;
    assign {io.out_q, io.out_tag} = fifo_rdata;
    assign io.busy      = (cnt_q != '0);

    // Credits cover both in-flight and buffered results.
    always_comb begin
        cnt_d = cnt_q;
        if (issue && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !issue)
            cnt_d = cnt_q - CW'(1);
    end

    // in_ready is registered from the next credit count so it stays low
    // through reset and never depends on in_valid combinationally.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            vld_sr_q   <= '0;
            tag_sr_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d < CREDITS);
            vld_sr_q   <= {issue, vld_sr_q[LATENCY-1:1]};
            tag_sr_q   <= {(issue ? io.in_tag : TAG_W'(0)), tag_sr_q[LATENCY-1:1]};
        end
    end

    // Stage 0 lines up with the unit's result; anything else on sqrt_q is dropped.
    fp_resp_fifo #(
        .WIDTH (FP32_W + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .areset  (areset),
        .wr_i    (vld_sr_q[0]),
        .wdata_i ({io.sqrt_q, tag_sr_q[0]}),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fp_sqrt_issue.sv
module tb_fp_sqrt_issue;
    import fp_sqrt_issue_pkg::*;

    localparam int TAG_W = 8;
    localparam int LAT   = 16;

    logic clk    = 1'b0;
    logic areset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fp_sqrt_issue_if #(.TAG_W(TAG_W)) bus ();

    fp_sqrt_issue #(
        .LATENCY    (LAT),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (32)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .io     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference FP32 helpers ----------------
    function automatic logic [31:0] d2s(input real r);
        logic [63:0] b;
        logic [23:0] m;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = int'(b[62:52]) - 1023 + 127;
        m = {1'b0, b[51:29]};
        if (b[28] && ((|b[27:0]) || b[29])) m = m + 24'd1;
        if (m[23]) begin
            m = 24'd0;
            e = e + 1;
        end
        return {b[63], 8'(e), m[22:0]};
    endfunction

    function automatic real s2r(input logic [31:0] a);
        logic [10:0] e;
        e = 11'(int'(a[30:23]) - 127 + 1023);
        return $bitstoreal({a[31], e, a[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] i2f(input int n);
        return d2s(real'(n));
    endfunction

    function automatic logic [31:0] sq(input logic [31:0] a);
        if (a[30:0] == 31'd0) return a;
        if (a[31]) return FP32_QNAN;
        if (a[30:23] == 8'hFF) return (a[22:0] != 23'd0) ? FP32_QNAN : a;
        if (a[30:23] == 8'h00) return 32'd0;
        return d2s($sqrt(s2r(a)));
    endfunction

    // ---------------- FPSqrt unit model: 16 stages, no reset ----------------
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= sq(bus.sqrt_a);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.sqrt_q = pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'h3F80_0000; bus.in_tag = 8'hAA; bus.out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_q !== 32'h0) begin errors++; $display("FAIL reset_out_q: got %h want 0", bus.out_q); end
        checks++; if (bus.out_tag !== 8'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
        checks++; if (bus.sqrt_a !== 32'h0) begin errors++; $display("FAIL reset_sqrt_a: got %h want 0", bus.sqrt_a); end
        bus.in_valid = 1'b0;
        areset = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL release_idle: out_valid %b busy %b want 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_single();
        int  c0;
        bit  seen;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 32'h4080_0000; bus.in_tag = 8'h05;
        #1;
        checks++; if (bus.sqrt_a !== 32'h4080_0000) begin errors++; $display("FAIL single_sqrt_a: got %h want 40800000", bus.sqrt_a); end
        c0 = cyc;
        tick();
        bus.in_valid = 1'b0; bus.in_a = 32'h0;
        #1;
        checks++; if (bus.busy !== 1'b1 || bus.sqrt_a !== 32'h0) begin errors++; $display("FAIL single_busy: busy %b sqrt_a %h want 1 0", bus.busy, bus.sqrt_a); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || (cyc - c0) != 17) begin errors++; $display("FAIL single_latency: got %0d (seen %b) want 17", cyc - c0, seen); end
        checks++; if (bus.out_q !== 32'h4000_0000) begin errors++; $display("FAIL single_q: got %h want 40000000", bus.out_q); end
        checks++; if (bus.out_tag !== 8'h05) begin errors++; $display("FAIL single_tag: got %h want 05", bus.out_tag); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_done: busy %b out_valid %b want 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rx = 0, first = -1, last = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (sent < 40) begin
                bus.in_valid = 1'b1; bus.in_a = i2f(sent + 1); bus.in_tag = 8'(sent);
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", i, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (bus.out_tag !== 8'(rx) || bus.out_q !== sq(i2f(rx + 1))) begin
                    errors++; $display("FAIL b2b_resp: got q %h tag %h want q %h tag %h", bus.out_q, bus.out_tag, sq(i2f(rx + 1)), 8'(rx));
                end
                if (rx == 1) begin
                    checks++; if (bus.out_q !== 32'h3FB5_04F3) begin errors++; $display("FAIL b2b_sqrt2: got %h want 3fb504f3", bus.out_q); end
                end
                rx++;
            end
            if (sent < 40 && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (rx != 40 || (last - first) != 39) begin errors++; $display("FAIL b2b_rate: got %0d resp over span %0d want 40 over 39", rx, last - first); end
    endtask

    task automatic test_credit_full();
        int acc = 0, extra = 0, ntag = 100, exp_t = 101;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.in_a = i2f(ntag); bus.in_tag = 8'(ntag);
            if (bus.in_ready) begin acc++; ntag++; end
            tick();
        end
        checks++; if (acc != 32) begin errors++; $display("FAIL full_accepts: got %0d want 32", acc); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'd100) begin errors++; $display("FAIL full_head: valid %b tag %0d want 1 100", bus.out_valid, bus.out_tag); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 30; i++) begin
            bus.in_a = i2f(ntag); bus.in_tag = 8'(ntag);
            if (bus.in_ready) begin extra++; ntag++; end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (extra != 1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_one_more: got %0d in_ready %b want 1 0", extra, bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 80 && exp_t <= 132; i++) begin
            if (bus.out_valid) begin
                checks++;
                if (bus.out_tag !== 8'(exp_t) || bus.out_q !== sq(i2f(exp_t))) begin
                    errors++; $display("FAIL full_drain: got q %h tag %0d want q %h tag %0d", bus.out_q, bus.out_tag, sq(i2f(exp_t)), exp_t);
                end
                exp_t++;
            end
            tick();
        end
        checks++; if (exp_t != 133 || bus.busy !== 1'b0) begin errors++; $display("FAIL full_drained: next %0d busy %b want 133 0", exp_t, bus.busy); end
    endtask

    task automatic test_special();
        logic [31:0] ops [3];
        logic [31:0] res [3];
        int n = 0;
        ops = '{32'h8000_0000, 32'h7F80_0000, 32'hBF80_0000};
        res = '{32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_a = ops[k]; bus.in_tag = 8'(8'hC0 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            if (bus.out_valid) begin
                checks++;
                if (bus.out_q !== res[n] || bus.out_tag !== 8'(8'hC0 + n)) begin
                    errors++; $display("FAIL special_%0d: got q %h tag %h want q %h tag %h", n, bus.out_q, bus.out_tag, res[n], 8'(8'hC0 + n));
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL special_count: got %0d want 3", n); end
    endtask

    task automatic test_reset_mid();
        int  c0, stray = 0;
        bit  seen;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i < 5); bus.in_a = i2f(25); bus.in_tag = 8'(50 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
        areset = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_now: out_valid %b busy %b in_ready %b want 0 0 0", bus.out_valid, bus.busy, bus.in_ready);
        end
        @(posedge clk); #1;
        areset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid || bus.busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray: got %0d active cycles want 0", stray); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_a = 32'h4280_0000; bus.in_tag = 8'd77;
        c0 = cyc;
        tick();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || (cyc - c0) != 17) begin errors++; $display("FAIL mid_latency: got %0d (seen %b) want 17", cyc - c0, seen); end
        checks++; if (bus.out_q !== 32'h4100_0000 || bus.out_tag !== 8'd77) begin errors++; $display("FAIL mid_resp: got q %h tag %0d want 41000000 77", bus.out_q, bus.out_tag); end
        tick();
    endtask

    task automatic test_back_to_back_pop();
        int acc = 0, ntag = 0, exp_t = 0, extra = 0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && acc < 31; i++) begin
            bus.in_a = i2f(ntag + 1); bus.in_tag = 8'(ntag);
            if (bus.in_ready) begin acc++; ntag++; end
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (20) tick();
        checks++; if (acc != 31 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL pop_setup: acc %0d out_valid %b in_ready %b want 31 1 1", acc, bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_a = i2f(ntag + 1); bus.in_tag = 8'(ntag);
            checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL pop_handshake: cycle %0d in_ready %b out_valid %b want 1 1", i, bus.in_ready, bus.out_valid);
            end
            if (bus.out_valid) begin
                checks++;
                if (bus.out_tag !== 8'(exp_t) || bus.out_q !== sq(i2f(exp_t + 1))) begin
                    errors++; $display("FAIL pop_order: got q %h tag %0d want q %h tag %0d", bus.out_q, bus.out_tag, sq(i2f(exp_t + 1)), exp_t);
                end
                exp_t++;
            end
            if (bus.in_ready) ntag++;
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (20) tick();
        // Credit count should sit at 31: exactly one more request fits.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_a = i2f(ntag + 1); bus.in_tag = 8'(ntag);
            if (bus.in_ready) begin extra++; ntag++; end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (extra != 1) begin errors++; $display("FAIL pop_credit: got %0d extra accepts want 1", extra); end
        repeat (20) tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_t < ntag; i++) begin
            if (bus.out_valid) begin
                checks++;
                if (bus.out_tag !== 8'(exp_t) || bus.out_q !== sq(i2f(exp_t + 1))) begin
                    errors++; $display("FAIL pop_drain: got q %h tag %0d want q %h tag %0d", bus.out_q, bus.out_tag, sq(i2f(exp_t + 1)), exp_t);
                end
                exp_t++;
            end
            tick();
        end
        checks++; if (exp_t != 42 || bus.busy !== 1'b0) begin errors++; $display("FAIL pop_done: got %0d busy %b want 42 0", exp_t, bus.busy); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = 32'h0; bus.in_tag = '0; bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_full();
        test_special();
        test_reset_mid();
        test_back_to_back_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
